// File: rtl/lane_sync_handler_pkg.sv
// Shared types and constants for the lane code-group synchronisation block.
package lane_sync_handler_pkg;

   typedef enum logic [1:0] {
      CS_INIT  = 2'd0,
      CS_CHECK = 2'd1,
      CS_DATA  = 2'd2
   } cs_state_e;

   localparam logic [7:0] K28_5     = 8'hBC;
   localparam int         ERR_CNT_W = 16;
   localparam int         LIM_W     = 4;

   // Increment that sticks at lim instead of wrapping.
   function automatic logic [LIM_W-1:0] sat_inc(input logic [LIM_W-1:0] v,
                                                input logic [LIM_W-1:0] lim);
      return (v >= lim) ? lim : v + 1'b1;
   endfunction

endpackage

// File: rtl/lane_sync_handler_cgs.sv
// Per-lane code-group sync FSM (INIT -> CHECK -> DATA), with an optional
// saturating bad-beat counter when LSH_ERR_CNT_EN is defined.
module lane_cgs_fsm
   import lane_sync_handler_pkg::*;
#(
   parameter int BYTES     = 8,
   parameter int K_CNT     = 4,
   parameter int ERR_LIMIT = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [BYTES*8-1:0] rx_data,
   input  logic [BYTES-1:0]   rx_k,
   input  logic [BYTES-1:0]   rx_cv,
   input  logic [BYTES-1:0]   rx_de,
   input  logic               rx_val,
   input  logic               sync_req,
`ifdef LSH_ERR_CNT_EN
   input  logic                 err_clr,
   output logic [ERR_CNT_W-1:0] err_cnt,
`endif
   output logic               lane_sync,
   output logic               in_init
);

   localparam logic [LIM_W-1:0] K_LIM = LIM_W'(K_CNT);
   localparam logic [LIM_W-1:0] E_LIM = LIM_W'(ERR_LIMIT);

   cs_state_e        state, state_nx;
   logic [LIM_W-1:0] k_cnt, k_nx;
   logic [LIM_W-1:0] bad_cnt, bad_nx;
   logic             all_k, k_beat, bad;

   always_comb begin
      all_k = 1'b1;
      for (int b = 0; b < BYTES; b++)
         if (!rx_k[b] || rx_data[b*8 +: 8] != K28_5) all_k = 1'b0;
   end

   assign k_beat  = rx_val & all_k;
   assign bad     = rx_val & (|rx_cv | |rx_de);
   assign in_init = (state == CS_INIT);

   always_comb begin
      state_nx = state;
      k_nx     = k_cnt;
      bad_nx   = bad_cnt;
      // Losing the lane or a resync request beats every other transition.
      if (!rx_val || sync_req) begin
         state_nx = CS_INIT;
         k_nx     = '0;
         bad_nx   = '0;
      end else begin
         case (state)
            CS_INIT: begin
               if (k_beat) begin
                  k_nx = sat_inc(k_cnt, K_LIM);
                  if (k_nx == K_LIM) state_nx = CS_CHECK;
               end else begin
                  k_nx = '0;
               end
            end
            CS_CHECK: begin
               if (bad) begin
                  state_nx = CS_INIT;
                  k_nx     = '0;
               end else if (!k_beat) begin
                  state_nx = CS_DATA;
                  bad_nx   = '0;
               end
            end
            CS_DATA: begin
               if (bad) begin
                  bad_nx = sat_inc(bad_cnt, E_LIM);
                  if (bad_nx == E_LIM) begin
                     state_nx = CS_INIT;
                     k_nx     = '0;
                     bad_nx   = '0;
                  end
               end else begin
                  bad_nx = '0;
               end
            end
            default: begin
               state_nx = CS_INIT;
               k_nx     = '0;
               bad_nx   = '0;
            end
         endcase
      end
   end

   // lane_sync is taken from the next state so it tracks state cycle-for-cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= CS_INIT;
         k_cnt     <= '0;
         bad_cnt   <= '0;
         lane_sync <= 1'b0;
      end else begin
         state     <= state_nx;
         k_cnt     <= k_nx;
         bad_cnt   <= bad_nx;
         lane_sync <= (state_nx == CS_DATA);
      end
   end

`ifdef LSH_ERR_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)                   err_cnt <= '0;
      else if (err_clr)          err_cnt <= '0;
      else if (bad && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
   end
`endif

endmodule

// File: rtl/lane_sync_handler.sv
// Multi-lane sync handler: one lane_cgs_fsm per lane plus link-level status.
// Optional per-lane error counters are enabled by defining LSH_ERR_CNT_EN.
module lane_sync_handler
   import lane_sync_handler_pkg::*;
#(
   parameter int LANES     = 2,
   parameter int BYTES     = 8,
   parameter int K_CNT     = 4,
   parameter int ERR_LIMIT = 3
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic [LANES*BYTES*8-1:0] Lane_Rx_Data,
   input  logic [LANES*BYTES-1:0]   Lane_Rx_K,
   input  logic [LANES*BYTES-1:0]   Lane_Rx_CV,
   input  logic [LANES*BYTES-1:0]   Lane_Rx_DE,
   input  logic [LANES-1:0]         Lane_Rx_Val,
   input  logic                     Sync_Req,
   input  logic                     Err_Clr,
`ifdef LSH_ERR_CNT_EN
   output logic [LANES*ERR_CNT_W-1:0] Err_Cnt,
`endif
   output logic [LANES-1:0]         Lane_Sync,
   output logic                     SYNC_OK,
   output logic                     Sync_N
);

   logic [LANES-1:0] in_init;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      lane_cgs_fsm #(
         .BYTES    (BYTES),
         .K_CNT    (K_CNT),
         .ERR_LIMIT(ERR_LIMIT)
      ) u_fsm (
         .clk      (Clock),
         .rst      (Reset),
         .rx_data  (Lane_Rx_Data[g*BYTES*8 +: BYTES*8]),
         .rx_k     (Lane_Rx_K[g*BYTES +: BYTES]),
         .rx_cv    (Lane_Rx_CV[g*BYTES +: BYTES]),
         .rx_de    (Lane_Rx_DE[g*BYTES +: BYTES]),
         .rx_val   (Lane_Rx_Val[g]),
         .sync_req (Sync_Req),
`ifdef LSH_ERR_CNT_EN
         .err_clr  (Err_Clr),
         .err_cnt  (Err_Cnt[g*ERR_CNT_W +: ERR_CNT_W]),
`endif
         .lane_sync(Lane_Sync[g]),
         .in_init  (in_init[g])
      );
   end

`ifndef LSH_ERR_CNT_EN
   // Err_Clr has nothing to clear in this build.
   logic unused_err_clr;
   assign unused_err_clr = Err_Clr;
`endif

   always_ff @(posedge Clock) begin
      if (Reset) begin
         SYNC_OK <= 1'b0;
         Sync_N  <= 1'b0;
      end else begin
         SYNC_OK <= &Lane_Sync;
         Sync_N  <= ~|in_init;
      end
   end

endmodule

// File: tb/tb_lane_sync_handler.sv
// Directed self-checking bench for lane_sync_handler (LANES=2, BYTES=8).
// Error-counter checks are compiled in when LSH_ERR_CNT_EN is defined.
module tb_lane_sync_handler;

   localparam int LANES = 2;
   localparam int BYTES = 8;
   localparam int K = 0, D = 1, B = 2, V = 3, E = 4;  // K, data, CV-bad, invalid, DE-bad

   logic                     Clock;
   logic                     Reset;
   logic [LANES*BYTES*8-1:0] Lane_Rx_Data;
   logic [LANES*BYTES-1:0]   Lane_Rx_K, Lane_Rx_CV, Lane_Rx_DE;
   logic [LANES-1:0]         Lane_Rx_Val;
   logic                     Sync_Req, Err_Clr;
   logic [LANES-1:0]         Lane_Sync;
   logic                     SYNC_OK, Sync_N;
`ifdef LSH_ERR_CNT_EN
   logic [LANES*16-1:0]      Err_Cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   lane_sync_handler #(.LANES(LANES), .BYTES(BYTES), .K_CNT(4), .ERR_LIMIT(3)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Lane_Rx_Data(Lane_Rx_Data),
      .Lane_Rx_K   (Lane_Rx_K),
      .Lane_Rx_CV  (Lane_Rx_CV),
      .Lane_Rx_DE  (Lane_Rx_DE),
      .Lane_Rx_Val (Lane_Rx_Val),
      .Sync_Req    (Sync_Req),
      .Err_Clr     (Err_Clr),
`ifdef LSH_ERR_CNT_EN
      .Err_Cnt     (Err_Cnt),
`endif
      .Lane_Sync   (Lane_Sync),
      .SYNC_OK     (SYNC_OK),
      .Sync_N      (Sync_N)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic drive_lane(input int ln, input int kind);
      Lane_Rx_Val[ln]                    = (kind != V);
      Lane_Rx_K[ln*BYTES +: BYTES]       = (kind == K) ? {BYTES{1'b1}} : {BYTES{1'b0}};
      Lane_Rx_Data[ln*BYTES*8 +: BYTES*8] = (kind == K) ? {BYTES{8'hBC}} : {BYTES{8'h5A}};
      Lane_Rx_CV[ln*BYTES +: BYTES]      = (kind == B) ? {{(BYTES-1){1'b0}}, 1'b1} : {BYTES{1'b0}};
      Lane_Rx_DE[ln*BYTES +: BYTES]      = (kind == E) ? {1'b1, {(BYTES-1){1'b0}}} : {BYTES{1'b0}};
   endtask

   // Present one beat on both lanes, clock it, and settle before sampling.
   task automatic beat(input int k0, input int k1);
      drive_lane(0, k0);
      drive_lane(1, k1);
      @(posedge Clock);
      #1;
   endtask

   task automatic sync_both();
      repeat (4) beat(K, K);
      repeat (2) beat(D, D);
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      beat(K, K);
      beat(K, K);
      n_cmp++; if (Lane_Sync !== 2'b00) begin n_bad++; $display("FAIL reset_lane_sync got=%b exp=00", Lane_Sync); end
      n_cmp++; if (SYNC_OK !== 1'b0) begin n_bad++; $display("FAIL reset_sync_ok got=%b exp=0", SYNC_OK); end
      n_cmp++; if (Sync_N !== 1'b0) begin n_bad++; $display("FAIL reset_sync_n got=%b exp=0", Sync_N); end
`ifdef LSH_ERR_CNT_EN
      n_cmp++; if (Err_Cnt !== '0) begin n_bad++; $display("FAIL reset_err_cnt got=%h exp=0", Err_Cnt); end
`endif
      Reset = 1'b0;
   endtask

   task automatic test_sync_up();
      for (int i = 0; i < 4; i++) begin
         beat(K, K);
         n_cmp++; if (Lane_Sync !== 2'b00) begin n_bad++; $display("FAIL up_k%0d_lane_sync got=%b exp=00", i, Lane_Sync); end
      end
      n_cmp++; if (Sync_N !== 1'b0) begin n_bad++; $display("FAIL up_k_sync_n got=%b exp=0", Sync_N); end
      beat(D, D);
      n_cmp++; if (Lane_Sync !== 2'b11) begin n_bad++; $display("FAIL up_data_lane_sync got=%b exp=11", Lane_Sync); end
      n_cmp++; if (SYNC_OK !== 1'b0) begin n_bad++; $display("FAIL up_data_sync_ok got=%b exp=0", SYNC_OK); end
      n_cmp++; if (Sync_N !== 1'b1) begin n_bad++; $display("FAIL up_data_sync_n got=%b exp=1", Sync_N); end
      beat(D, D);
      n_cmp++; if (SYNC_OK !== 1'b1) begin n_bad++; $display("FAIL up_sync_ok got=%b exp=1", SYNC_OK); end
   endtask

   task automatic test_k_restart();
      Sync_Req = 1'b1;
      beat(D, D);
      Sync_Req = 1'b0;
      // Lane 1: 3 K, 1 data, 3 K -- never four in a row.
      for (int i = 0; i < 7; i++) begin
         beat(K, (i == 3) ? D : K);
         n_cmp++; if (Lane_Sync !== 2'b00 || SYNC_OK !== 1'b0) begin
            n_bad++; $display("FAIL krs_%0d got lane_sync=%b sync_ok=%b exp 00/0", i, Lane_Sync, SYNC_OK);
         end
      end
      beat(D, D);
      n_cmp++; if (Lane_Sync !== 2'b01) begin n_bad++; $display("FAIL krs_partial_lane_sync got=%b exp=01", Lane_Sync); end
      n_cmp++; if (Sync_N !== 1'b0) begin n_bad++; $display("FAIL krs_partial_sync_n got=%b exp=0", Sync_N); end
      for (int i = 0; i < 4; i++) begin
         beat(D, K);
         n_cmp++; if (SYNC_OK !== 1'b0) begin n_bad++; $display("FAIL krs_k4_%0d_sync_ok got=%b exp=0", i, SYNC_OK); end
      end
      beat(D, D);
      n_cmp++; if (Lane_Sync !== 2'b11) begin n_bad++; $display("FAIL krs_full_lane_sync got=%b exp=11", Lane_Sync); end
      n_cmp++; if (SYNC_OK !== 1'b0) begin n_bad++; $display("FAIL krs_full_sync_ok got=%b exp=0", SYNC_OK); end
      beat(D, D);
      n_cmp++; if (SYNC_OK !== 1'b1) begin n_bad++; $display("FAIL krs_final_sync_ok got=%b exp=1", SYNC_OK); end
   endtask

   task automatic test_bad_beats();
      int seq[6] = '{B, E, D, B, E, D};
      foreach (seq[i]) begin
         beat(seq[i], D);
         n_cmp++; if (Lane_Sync !== 2'b11 || SYNC_OK !== 1'b1) begin
            n_bad++; $display("FAIL bad_hold_%0d got lane_sync=%b sync_ok=%b exp 11/1", i, Lane_Sync, SYNC_OK);
         end
      end
      beat(B, D);
      beat(E, D);
      n_cmp++; if (Lane_Sync !== 2'b11) begin n_bad++; $display("FAIL bad_two_lane_sync got=%b exp=11", Lane_Sync); end
      beat(B, D);
      n_cmp++; if (Lane_Sync !== 2'b10) begin n_bad++; $display("FAIL bad_three_lane_sync got=%b exp=10", Lane_Sync); end
      beat(D, D);
      n_cmp++; if (SYNC_OK !== 1'b0) begin n_bad++; $display("FAIL bad_three_sync_ok got=%b exp=0", SYNC_OK); end
      n_cmp++; if (Sync_N !== 1'b0) begin n_bad++; $display("FAIL bad_three_sync_n got=%b exp=0", Sync_N); end
      sync_both();
      n_cmp++; if (SYNC_OK !== 1'b1) begin n_bad++; $display("FAIL bad_resync_sync_ok got=%b exp=1", SYNC_OK); end
   endtask

   task automatic test_check_bad();
      Sync_Req = 1'b1;
      beat(K, K);
      Sync_Req = 1'b0;
      repeat (4) beat(K, K);
      beat(B, D);
      n_cmp++; if (Lane_Sync !== 2'b10) begin n_bad++; $display("FAIL chk_bad_lane_sync got=%b exp=10", Lane_Sync); end
      beat(D, D);
      n_cmp++; if (Lane_Sync !== 2'b10) begin n_bad++; $display("FAIL chk_bad_hold_lane_sync got=%b exp=10", Lane_Sync); end
      sync_both();
      n_cmp++; if (Lane_Sync !== 2'b11) begin n_bad++; $display("FAIL chk_resync_lane_sync got=%b exp=11", Lane_Sync); end
   endtask

   task automatic test_sync_req();
      Sync_Req = 1'b1;
      beat(K, K);
      Sync_Req = 1'b0;
      n_cmp++; if (Lane_Sync !== 2'b00) begin n_bad++; $display("FAIL req_lane_sync got=%b exp=00", Lane_Sync); end
      beat(K, K);
      n_cmp++; if (Sync_N !== 1'b0 || SYNC_OK !== 1'b0) begin
         n_bad++; $display("FAIL req_status got sync_n=%b sync_ok=%b exp 0/0", Sync_N, SYNC_OK);
      end
      // The K during the request must not count: only 3 counted so far.
      beat(K, K);
      beat(K, K);
      beat(D, D);
      n_cmp++; if (Lane_Sync !== 2'b00) begin n_bad++; $display("FAIL req_priority_lane_sync got=%b exp=00", Lane_Sync); end
      sync_both();
      n_cmp++; if (SYNC_OK !== 1'b1 || Sync_N !== 1'b1) begin
         n_bad++; $display("FAIL req_resync got sync_ok=%b sync_n=%b exp 1/1", SYNC_OK, Sync_N);
      end
   endtask

   task automatic test_val_drop();
      beat(D, V);
      n_cmp++; if (Lane_Sync !== 2'b01) begin n_bad++; $display("FAIL val_lane_sync got=%b exp=01", Lane_Sync); end
      beat(D, D);
      n_cmp++; if (Lane_Sync !== 2'b01) begin n_bad++; $display("FAIL val_hold_lane_sync got=%b exp=01", Lane_Sync); end
      n_cmp++; if (SYNC_OK !== 1'b0 || Sync_N !== 1'b0) begin
         n_bad++; $display("FAIL val_status got sync_ok=%b sync_n=%b exp 0/0", SYNC_OK, Sync_N);
      end
      repeat (4) beat(D, K);
      beat(D, D);
      n_cmp++; if (Lane_Sync !== 2'b11) begin n_bad++; $display("FAIL val_resync_lane_sync got=%b exp=11", Lane_Sync); end
   endtask

   task automatic test_reset_mid();
      beat(D, D);
      Reset = 1'b1; Sync_Req = 1'b1; Err_Clr = 1'b1;
      beat(K, K);
      n_cmp++; if (Lane_Sync !== 2'b00 || SYNC_OK !== 1'b0 || Sync_N !== 1'b0) begin
         n_bad++; $display("FAIL mid_reset got lane_sync=%b sync_ok=%b sync_n=%b exp 00/0/0", Lane_Sync, SYNC_OK, Sync_N);
      end
      Reset = 1'b0; Sync_Req = 1'b0; Err_Clr = 1'b0;
   endtask

`ifdef LSH_ERR_CNT_EN
   task automatic test_err_cnt();
      for (int i = 0; i < 5; i++) beat(B, (i < 2) ? E : D);
      n_cmp++; if (Err_Cnt[15:0] !== 16'd5) begin n_bad++; $display("FAIL err5 got=%0d exp=5", Err_Cnt[15:0]); end
      n_cmp++; if (Err_Cnt[31:16] !== 16'd2) begin n_bad++; $display("FAIL err_lane1 got=%0d exp=2", Err_Cnt[31:16]); end
      Err_Clr = 1'b1;
      beat(B, B);
      Err_Clr = 1'b0;
      n_cmp++; if (Err_Cnt !== 32'd0) begin n_bad++; $display("FAIL err_clr got=%h exp=0", Err_Cnt); end
      repeat (70000) beat(B, D);
      n_cmp++; if (Err_Cnt[15:0] !== 16'hFFFF) begin n_bad++; $display("FAIL err_sat got=%h exp=ffff", Err_Cnt[15:0]); end
   endtask
`endif

   initial begin
      Reset = 1'b1; Sync_Req = 1'b0; Err_Clr = 1'b0;
      Lane_Rx_Data = '0; Lane_Rx_K = '0; Lane_Rx_CV = '0; Lane_Rx_DE = '0; Lane_Rx_Val = '0;
      test_reset();
      test_sync_up();
      test_k_restart();
      test_bad_beats();
      test_check_bad();
      test_sync_req();
      test_val_drop();
      test_reset_mid();
`ifdef LSH_ERR_CNT_EN
      test_err_cnt();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lane_sync_handler.md
LANE_SYNC_HANDLER -- requirements
Module: lane_sync_handler

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning number of receive lanes (1..4).
REQ-002 SHALL have parameter BYTES, default 8, meaning bytes per lane per beat (2, 4 or 8).
REQ-003 SHALL have parameter K_CNT, default 4, meaning consecutive K28.5 beats needed to leave CS_INIT (1..15).
REQ-004 SHALL have parameter ERR_LIMIT, default 3, meaning consecutive bad beats that force CS_INIT (1..15).
REQ-005 SHALL have ports: Clock  in  1  rx word clock; Reset  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: Lane_Rx_Data  in  LANES*BYTES*8  lane data, lane 0 in the LSBs; Lane_Rx_K  in  LANES*BYTES  K flag per byte.
REQ-007 SHALL have ports: Lane_Rx_CV  in  LANES*BYTES  code violation; Lane_Rx_DE  in  LANES*BYTES  disparity error; Lane_Rx_Val  in  LANES  lane valid.
REQ-008 SHALL have ports: Sync_Req  in  1  resynchronise request; Err_Clr  in  1  clear error counters.
REQ-009 SHALL have ports: Lane_Sync  out  LANES  lane in CS_DATA; SYNC_OK  out  1  all lanes in CS_DATA; Sync_N  out  1  low while any lane in CS_INIT.
REQ-010 SHALL have port Err_Cnt  out  LANES*16  per-lane error count (present only under LSH_ERR_CNT_EN).

Function
REQ-011 SHALL classify each lane beat: K beat = every byte K=1 and data 8'hBC; bad beat = any byte CV or DE high; K/bad evaluated only when the lane's Rx_Val is high.
REQ-012 SHALL run one independent FSM per lane with states CS_INIT, CS_CHECK, CS_DATA.
REQ-013 CS_INIT: count consecutive K beats; any non-K beat clears the count; count reaching K_CNT moves to CS_CHECK next cycle.
REQ-014 CS_CHECK: K beat stays; good non-K beat moves to CS_DATA; bad beat returns to CS_INIT.
REQ-015 CS_DATA: count consecutive bad beats, any good beat clears it; count reaching ERR_LIMIT moves to CS_INIT.
REQ-016 Rx_Val low for a lane SHALL move that lane to CS_INIT next cycle and clear its counters, overriding all other transitions.
REQ-017 Sync_Req high SHALL move every lane to CS_INIT next cycle and hold there while high; takes priority over K-beat counting.
REQ-018 Lane_Sync[i] SHALL be registered, high exactly when lane i is in CS_DATA (same cycle as state).
REQ-019 SYNC_OK SHALL be registered from AND of Lane_Sync, i.e. one cycle after the last lane enters CS_DATA, and drop one cycle after any lane leaves it.
REQ-020 Sync_N SHALL be registered, low one cycle after any lane is in CS_INIT, high otherwise.
REQ-021 K-beat and bad-beat counters SHALL saturate at their limits and never wrap.

Reset
REQ-022 Reset SHALL put all lanes in CS_INIT, clear all counters, drive Lane_Sync=0, SYNC_OK=0, Sync_N=0, Err_Cnt=0.
REQ-023 Reset asserted mid-operation SHALL take effect on the next Clock edge, overriding Sync_Req and Err_Clr.

Configuration
REQ-024 With LSH_ERR_CNT_EN defined, each lane SHALL count bad beats in any state into a 16-bit saturating counter (holds at 16'hFFFF), cleared by Err_Clr; Err_Clr and a bad beat in the same cycle yield 0.
REQ-025 Without LSH_ERR_CNT_EN, Err_Cnt port and counters SHALL be absent; Err_Clr SHALL be ignored.

Structure
REQ-026 A shared package SHALL hold the state enum (CS_INIT/CS_CHECK/CS_DATA), the K28.5 constant 8'hBC and the counter width constant 16.
REQ-027 Per-lane logic SHALL be one sub-module lane_cgs_fsm, instantiated LANES times by generate.

Verification (LANES=2, BYTES=8, K_CNT=4, ERR_LIMIT=3)
REQ-028 Reset, then 4 K beats both lanes, then 1 data beat -> Lane_Sync=2'b11 on beat after data, SYNC_OK=1 one cycle later, Sync_N=1.
REQ-029 Lane 1 sends 3 K beats, 1 data beat, 4 K beats -> lane 1 stays in CS_INIT until fourth consecutive K; SYNC_OK held 0 throughout.
REQ-030 Synced link, lane 0 gets 2 bad beats, good, 2 bad -> stays synced; then 3 consecutive bad -> Lane_Sync=2'b10, SYNC_OK=0 and Sync_N=0 next cycle.
REQ-031 Synced link, Sync_Req pulsed 1 cycle -> both lanes CS_INIT, Sync_N=0; resync after 4 K beats plus data.
REQ-032 Lane_Rx_Val[1] low 1 cycle while synced -> lane 1 to CS_INIT, lane 0 unaffected.
REQ-033 With LSH_ERR_CNT_EN: 5 bad beats on lane 0 -> Err_Cnt[15:0]=5; Err_Clr coincident with bad beat -> 0; 70000 bad beats -> 16'hFFFF.
